// File: rtl/x2050_pkg.sv
// Shared definitions for the 2050 stat datapath: micro-op codes and the
// IBM bit-order helper (bit 0 is the nibble MSB).
package x2050_pkg;

  localparam logic [2:0] STOP_NOP  = 3'd0;
  localparam logic [2:0] STOP_LOAD = 3'd1;
  localparam logic [2:0] STOP_OR   = 3'd2;
  localparam logic [2:0] STOP_CLR  = 3'd3;
  localparam logic [2:0] STOP_LDC  = 3'd4;
  localparam logic [2:0] STOP_ORC  = 3'd5;
  localparam logic [2:0] STOP_CCLR = 3'd6;
  localparam logic [2:0] STOP_XOR  = 3'd7;

  // IBM numbering: bit 0 lives in the MSB of the nibble.
  function automatic logic stat_bit(input logic [3:0] nib, input logic [1:0] ibm_bit);
    return nib[2'd3 - ibm_bit];
  endfunction

endpackage

// File: rtl/x2050_stat_nib.sv
// Next-state function of one 4-bit stat group; holds when not enabled.
module x2050_stat_nib
  import x2050_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] e,
  input  logic [3:0] cond,
  input  logic [3:0] cur,
  input  logic       en,
  output logic [3:0] nxt
);

  always_comb begin
    nxt = cur;
    if (en) begin
      case (op)
        STOP_LOAD: nxt = e;
        STOP_OR:   nxt = cur | e;
        STOP_CLR:  nxt = cur & ~e;
        STOP_LDC:  nxt = cond;
        STOP_ORC:  nxt = cur | cond;
        STOP_CCLR: nxt = stat_bit(cur, 2'd0) ? (cur & ~e) : cur;
        STOP_XOR:  nxt = cur ^ e;
        default:   nxt = cur;
      endcase
    end
  end

endmodule

// File: rtl/x2050_stat_bank.sv
// Stat register bank: NGRP nibble groups with group decode, single-deep
// snapshot/restore for instruction retry, and an illegal-request pulse.
module x2050_stat_bank
  import x2050_pkg::*;
#(
  parameter  int NGRP = 2,
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int W    = 4 * NGRP
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ros_advance,
  input  logic [2:0]    i_op,
  input  logic [GW-1:0] i_grp,
  input  logic [3:0]    i_e,
  input  logic [3:0]    i_cond,
  input  logic          i_snap,
  input  logic          i_restore,
  output logic [W-1:0]  o_stat,
  output logic [NGRP-1:0] o_any,
  output logic          o_snap_valid,
  output logic          o_err
);

  logic [W-1:0] stat_reg;
  logic [W-1:0] stat_next;
  logic [W-1:0] snap_reg;
  logic         snap_valid_reg;
  logic         err_reg;

  logic grp_ok;
  logic op_live;
  logic bad_grp;
  logic restore_go;
  logic bad_restore;

  assign grp_ok      = (32'(i_grp) < 32'(NGRP));
  assign op_live     = (i_op != STOP_NOP) && grp_ok;
  assign bad_grp     = (i_op != STOP_NOP) && !grp_ok;
  assign restore_go  = i_restore && snap_valid_reg;
  assign bad_restore = i_restore && !snap_valid_reg;

  // Group 0 occupies the top nibble of the bus.
  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      x2050_stat_nib u_nib (
        .op   (i_op),
        .e    (i_e),
        .cond (i_cond),
        .cur  (stat_reg[W-1-4*gi -: 4]),
        .en   (op_live && (32'(i_grp) == gi)),
        .nxt  (stat_next[W-1-4*gi -: 4])
      );
      assign o_any[gi] = |stat_reg[W-1-4*gi -: 4];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stat_reg       <= '0;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else if (!i_ros_advance) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= bad_grp || bad_restore;
      if (restore_go) begin
        // A successful restore consumes the snapshot and discards the op and any snap.
        stat_reg       <= snap_reg;
        snap_valid_reg <= 1'b0;
      end else begin
        stat_reg <= stat_next;
        if (i_snap) begin
          snap_reg       <= stat_reg;
          snap_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign o_stat       = stat_reg;
  assign o_snap_valid = snap_valid_reg;
  assign o_err        = err_reg;

endmodule

// File: tb/tb_x2050_stat_bank.sv
// Randomized and directed check of x2050_stat_bank (NGRP=3) against an
// array-based reference model of the stat groups and snapshot.
module tb_x2050_stat_bank;

  localparam int NGRP = 3;
  localparam int GW   = 2;
  localparam int W    = 12;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_ros_advance;
  logic [2:0]    i_op;
  logic [GW-1:0] i_grp;
  logic [3:0]    i_e;
  logic [3:0]    i_cond;
  logic          i_snap;
  logic          i_restore;
  logic [W-1:0]  o_stat;
  logic [NGRP-1:0] o_any;
  logic          o_snap_valid;
  logic          o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: groups indexed by number, nibble written MSB = IBM bit 0.
  logic [3:0] m_stat [NGRP];
  logic [3:0] m_snap [NGRP];
  logic       m_valid;
  logic       m_err;

  x2050_stat_bank #(.NGRP(NGRP)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ros_advance (i_ros_advance),
    .i_op          (i_op),
    .i_grp         (i_grp),
    .i_e           (i_e),
    .i_cond        (i_cond),
    .i_snap        (i_snap),
    .i_restore     (i_restore),
    .o_stat        (o_stat),
    .o_any         (o_any),
    .o_snap_valid  (o_snap_valid),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    for (int g = 0; g < NGRP; g++) w[W-1-4*g -: 4] = m_stat[g];
    return w;
  endfunction

  function automatic logic [NGRP-1:0] model_any();
    logic [NGRP-1:0] a;
    for (int g = 0; g < NGRP; g++) a[g] = (m_stat[g] != 4'd0);
    return a;
  endfunction

  function automatic logic [3:0] apply_op(input int op, input logic [3:0] s,
                                          input logic [3:0] e, input logic [3:0] c);
    case (op)
      1: return e;
      2: return s | e;
      3: return s & ~e;
      4: return c;
      5: return s | c;
      6: return (s[3] == 1'b1) ? (s & ~e) : s;
      7: return s ^ e;
      default: return s;
    endcase
  endfunction

  task automatic model_update();
    logic [3:0] old [NGRP];
    if (i_reset) begin
      for (int g = 0; g < NGRP; g++) begin m_stat[g] = 0; m_snap[g] = 0; end
      m_valid = 0; m_err = 0;
    end else if (!i_ros_advance) begin
      m_err = 0;
    end else begin
      m_err = (i_op != 0 && int'(i_grp) >= NGRP) || (i_restore && !m_valid);
      if (i_restore && m_valid) begin
        for (int g = 0; g < NGRP; g++) m_stat[g] = m_snap[g];
        m_valid = 0;
      end else begin
        for (int g = 0; g < NGRP; g++) old[g] = m_stat[g];
        if (int'(i_grp) < NGRP)
          m_stat[i_grp] = apply_op(int'(i_op), m_stat[i_grp], i_e, i_cond);
        if (i_snap) begin
          for (int g = 0; g < NGRP; g++) m_snap[g] = old[g];
          m_valid = 1;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic adv, input int op, input int grp,
                      input logic [3:0] e, input logic [3:0] c,
                      input logic snap, input logic rest);
    i_reset = rst; i_ros_advance = adv; i_op = 3'(op); i_grp = GW'(grp);
    i_e = e; i_cond = c; i_snap = snap; i_restore = rest;
    model_update();
    @(posedge i_clk);
    #1;
    $display("txn rst=%0b adv=%0b op=%0d grp=%0d e=%h c=%h snap=%0b rst_req=%0b -> stat=%h any=%b sv=%0b err=%0b",
             rst, adv, op, grp, e, c, snap, rest, o_stat, o_any, o_snap_valid, o_err);
    check_val("stat", 32'(o_stat), 32'(model_word()));
    check_val("any", 32'(o_any), 32'(model_any()));
    check_val("snap_valid", 32'(o_snap_valid), 32'(m_valid));
    check_val("err", 32'(o_err), 32'(m_err));
  endtask

  initial begin
    i_reset = 1; i_ros_advance = 0; i_op = 0; i_grp = 0; i_e = 0; i_cond = 0;
    i_snap = 0; i_restore = 0;
    for (int g = 0; g < NGRP; g++) begin m_stat[g] = 4'hF; m_snap[g] = 4'hF; end
    m_valid = 1; m_err = 1;

    step(1, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    step(1, 1, 1, 0, 4'hF, 4'h0, 1, 0);
    check_val("reset_stat", 32'(o_stat), 32'h000);

    // Basic load / or / clr
    step(0, 1, 1, 0, 4'b1010, 4'h0, 0, 0);
    check_val("load_g0", 32'(o_stat), 32'hA00);
    check_val("load_any", 32'(o_any), 32'b001);
    step(0, 1, 2, 1, 4'b0011, 4'h0, 0, 0);
    check_val("or_g1", 32'(o_stat), 32'hA30);
    step(0, 1, 3, 0, 4'b1000, 4'h0, 0, 0);
    check_val("clr_g0", 32'(o_stat), 32'h230);

    // Conditional clear: bit0 clear holds, bit0 set clears
    step(0, 1, 6, 1, 4'hF, 4'h0, 0, 0);
    check_val("cclr_hold", 32'(o_stat), 32'h230);
    step(0, 1, 1, 1, 4'b1001, 4'h0, 0, 0);
    step(0, 1, 6, 1, 4'hF, 4'h0, 0, 0);
    check_val("cclr_clear", 32'(o_stat), 32'h200);

    // Advance low freezes everything
    step(0, 0, 1, 0, 4'hF, 4'h0, 1, 0);
    check_val("noadv_stat", 32'(o_stat), 32'h200);
    check_val("noadv_sv", 32'(o_snap_valid), 32'h0);

    // Snapshot / restore
    step(0, 1, 1, 0, 4'h5, 4'h0, 0, 0);
    step(0, 1, 1, 1, 4'hC, 4'h0, 0, 0);
    step(0, 1, 0, 0, 4'h0, 4'h0, 1, 0);
    check_val("snap_valid_set", 32'(o_snap_valid), 32'h1);
    step(0, 1, 7, 0, 4'hF, 4'h0, 0, 0);
    check_val("xor_g0", 32'(o_stat), 32'hAC0);
    step(0, 1, 1, 2, 4'h7, 4'h0, 0, 1);
    check_val("restore_stat", 32'(o_stat), 32'h5C0);
    check_val("restore_sv", 32'(o_snap_valid), 32'h0);
    step(0, 1, 0, 0, 4'h0, 4'h0, 0, 1);
    check_val("restore2_err", 32'(o_err), 32'h1);
    check_val("restore2_stat", 32'(o_stat), 32'h5C0);
    step(0, 1, 0, 0, 4'h0, 4'h0, 0, 0);
    check_val("err_pulse_end", 32'(o_err), 32'h0);

    // Out-of-range group
    step(0, 1, 1, 3, 4'hF, 4'h0, 0, 0);
    check_val("badgrp_err", 32'(o_err), 32'h1);
    check_val("badgrp_stat", 32'(o_stat), 32'h5C0);
    step(0, 1, 0, 3, 4'hF, 4'h0, 0, 0);
    check_val("badgrp_nop_err", 32'(o_err), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
